csa_accum_stream: RTL

- Parametrised sequential successor to the 4-bit carry-save adder.
- Accepts a stream of unsigned operands per frame and accumulates them in redundant carry-save form (sum/carry registers), with one 3:2 compression per accepted operand.
- At frame end, resolves sum+carry with a single carry-propagate add, flags overflow and reports the operand count.
- Sits between the multiplier partial-product path and the UART/SPI result formatter.

---
 rtl/csa_pkg.sv | 27 ++
 rtl/csa_row.sv | 20 ++
 rtl/fa.sv | 11 +
 rtl/csa_accum_stream.sv | 133 +++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save accumulating stream adder.
package csa_pkg;

    localparam int unsigned CSA_MAX_W = 64;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } csa_state_t;

    // Clears every bit at or above position w, so a narrow operand widens with zeros.
    function automatic logic [CSA_MAX_W-1:0] csa_zext(input logic [CSA_MAX_W-1:0] v,
                                                      input int unsigned w);
        logic [CSA_MAX_W-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < CSA_MAX_W; k++) begin
            if (k < w) begin
                r[k] = v[k];
            end else begin
                r[k] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/csa_row.sv
// ACC_W-bit 3:2 compressor row; maj is left unshifted for the caller to weight.
module csa_row #(
    parameter int unsigned ACC_W = 16
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    input  logic [ACC_W-1:0] c_i,
    output logic [ACC_W-1:0] sum_o,
    output logic [ACC_W-1:0] maj_o
);
    for (genvar g = 0; g < ACC_W; g++) begin : g_bit
        fa u_fa (
            .a_i  (a_i[g]),
            .b_i  (b_i[g]),
            .ci_i (c_i[g]),
            .s_o  (sum_o[g]),
            .co_o (maj_o[g])
        );
    end
endmodule

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule

// File: rtl/csa_accum_stream.sv
// Streams unsigned operands into a carry-save accumulator and resolves the
// frame total with one carry-propagate add when the last operand arrives.
module csa_accum_stream
    import csa_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_cnt
);

    csa_state_t       state_q, state_d;
    logic [ACC_W-1:0] s_q, s_d;
    logic [ACC_W-1:0] c_q, c_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             ovfo_q, ovfo_d;
    logic [CNT_W-1:0] cnto_q, cnto_d;

    logic [ACC_W-1:0] a_s;
    logic [ACC_W-1:0] row_sum_s;
    logic [ACC_W-1:0] row_maj_s;
    logic [ACC_W:0]   t_s;
    logic             accept_s;

    assign a_s      = ACC_W'(csa_zext(CSA_MAX_W'(in_data), W));
    assign accept_s = in_valid & (state_q == ACCUM);
    assign t_s      = {1'b0, s_q} + {1'b0, c_q};

    csa_row #(.ACC_W(ACC_W)) u_row (
        .a_i   (a_s),
        .b_i   (s_q),
        .c_i   (c_q),
        .sum_o (row_sum_s),
        .maj_o (row_maj_s)
    );

    // Next-state and datapath update for the accumulate/resolve/hand-off sequence.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        ovfo_d  = ovfo_q;
        cnto_d  = cnto_q;
        case (state_q)
            ACCUM: begin
                if (accept_s) begin
                    s_d   = row_sum_s;
                    c_d   = {row_maj_s[ACC_W-2:0], 1'b0};
                    // The majority bit shifted out of the top is worth 2^ACC_W.
                    ovf_d = ovf_q | row_maj_s[ACC_W-1];
                    if (cnt_q == {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q;
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    if (in_last) begin
                        state_d = RESOLVE;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            RESOLVE: begin
                sum_d   = t_s[ACC_W-1:0];
                ovfo_d  = ovf_q | t_s[ACC_W];
                cnto_d  = cnt_q;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    s_d     = '0;
                    c_d     = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State and datapath registers; reset discards any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            s_q     <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            ovfo_q  <= 1'b0;
            cnto_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            ovfo_q  <= ovfo_d;
            cnto_q  <= cnto_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_ovf   = ovfo_q;
    assign out_cnt   = cnto_q;

endmodule
